// File: rtl/rgb_pwm_fader.sv
// RGB PWM output stage: accepts a target colour and fades per-channel levels toward it, one LSB
// per step. Define RGB_FADER_GAMMA_EN for a square-law duty curve; the default build is linear.
module rgb_pwm_fader #(
    parameter int unsigned PWM_BITS      = 8,
    parameter int unsigned STEP_INTERVAL = 47000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                color_valid,
    output logic                color_ready,
    input  logic [PWM_BITS-1:0] color_r,
    input  logic [PWM_BITS-1:0] color_g,
    input  logic [PWM_BITS-1:0] color_b,
    output logic                fade_done,
    output logic                RGB_R,
    output logic                RGB_G,
    output logic                RGB_B
);

    localparam int unsigned StepW = (STEP_INTERVAL > 1) ? $clog2(STEP_INTERVAL) : 1;
    localparam logic [StepW-1:0] StepLast = StepW'(STEP_INTERVAL - 1);

    typedef enum logic [0:0] {
        StIdle,
        StFading
    } state_e;

    state_e              state_q, state_d;
    logic [PWM_BITS-1:0] level_r_q, level_g_q, level_b_q;
    logic [PWM_BITS-1:0] level_r_d, level_g_d, level_b_d;
    logic [PWM_BITS-1:0] target_r_q, target_g_q, target_b_q;
    logic [PWM_BITS-1:0] target_r_d, target_g_d, target_b_d;
    logic [StepW-1:0]    step_cnt_q, step_cnt_d;
    logic [PWM_BITS-1:0] pwm_cnt_q;
    logic                fade_done_q, fade_done_d;
    logic [PWM_BITS-1:0] duty_r, duty_g, duty_b;
    logic                accept;
    logic                step_tick;

    // Only ever moves one LSB toward the target, so levels can never wrap.
    function automatic logic [PWM_BITS-1:0] step_toward(input logic [PWM_BITS-1:0] lvl,
                                                        input logic [PWM_BITS-1:0] tgt);
        logic [PWM_BITS-1:0] res;
        res = lvl;
        if (lvl < tgt) begin
            res = lvl + PWM_BITS'(1);
        end else if (lvl > tgt) begin
            res = lvl - PWM_BITS'(1);
        end
        return res;
    endfunction

`ifdef RGB_FADER_GAMMA_EN
    function automatic logic [PWM_BITS-1:0] gamma(input logic [PWM_BITS-1:0] lvl);
        logic [2*PWM_BITS-1:0] wide;
        logic [2*PWM_BITS-1:0] sq;
        wide = {{PWM_BITS{1'b0}}, lvl};
        sq   = wide * wide;
        return PWM_BITS'(sq >> PWM_BITS);
    endfunction

    assign duty_r = gamma(level_r_q);
    assign duty_g = gamma(level_g_q);
    assign duty_b = gamma(level_b_q);
`else
    assign duty_r = level_r_q;
    assign duty_g = level_g_q;
    assign duty_b = level_b_q;
`endif

    assign color_ready = (state_q == StIdle) && !rst;
    assign accept      = color_valid && color_ready;
    assign step_tick   = (state_q == StFading) && (step_cnt_q == StepLast);
    assign fade_done   = fade_done_q;

    always_comb begin
        state_d     = state_q;
        level_r_d   = level_r_q;
        level_g_d   = level_g_q;
        level_b_d   = level_b_q;
        target_r_d  = target_r_q;
        target_g_d  = target_g_q;
        target_b_d  = target_b_q;
        step_cnt_d  = step_cnt_q;
        fade_done_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                step_cnt_d = '0;
                if (accept) begin
                    target_r_d = color_r;
                    target_g_d = color_g;
                    target_b_d = color_b;
                    if ((color_r == level_r_q) && (color_g == level_g_q) &&
                        (color_b == level_b_q)) begin
                        fade_done_d = 1'b1;
                    end else begin
                        state_d = StFading;
                    end
                end
            end
            StFading: begin
                if (step_tick) begin
                    step_cnt_d = '0;
                    level_r_d  = step_toward(level_r_q, target_r_q);
                    level_g_d  = step_toward(level_g_q, target_g_q);
                    level_b_d  = step_toward(level_b_q, target_b_q);
                    if ((level_r_d == target_r_q) && (level_g_d == target_g_q) &&
                        (level_b_d == target_b_q)) begin
                        state_d     = StIdle;
                        fade_done_d = 1'b1;
                    end
                end else begin
                    step_cnt_d = step_cnt_q + StepW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            level_r_q   <= '0;
            level_g_q   <= '0;
            level_b_q   <= '0;
            target_r_q  <= '0;
            target_g_q  <= '0;
            target_b_q  <= '0;
            step_cnt_q  <= '0;
            pwm_cnt_q   <= '0;
            fade_done_q <= 1'b0;
            RGB_R       <= 1'b1;
            RGB_G       <= 1'b1;
            RGB_B       <= 1'b1;
        end else begin
            state_q     <= state_d;
            level_r_q   <= level_r_d;
            level_g_q   <= level_g_d;
            level_b_q   <= level_b_d;
            target_r_q  <= target_r_d;
            target_g_q  <= target_g_d;
            target_b_q  <= target_b_d;
            step_cnt_q  <= step_cnt_d;
            pwm_cnt_q   <= pwm_cnt_q + PWM_BITS'(1);
            fade_done_q <= fade_done_d;
            // Pins are active-low: lit while the counter is below the duty value.
            RGB_R       <= !(pwm_cnt_q < duty_r);
            RGB_G       <= !(pwm_cnt_q < duty_g);
            RGB_B       <= !(pwm_cnt_q < duty_b);
        end
    end

endmodule
